// File: rtl/pe_pair_feeder.sv
// Sparse operand pairing stage: buffers one tile of nonzero weights/activations,
// walks their Cartesian product (activation outer, weight inner) and issues groups of three pairs.
module pe_pair_feeder #(
    parameter int W_DEPTH  = 8,
    parameter int IA_DEPTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_w_valid,
    input  logic signed [15:0]      i_w_data,
    input  logic [2:0][6:0]         i_w_addr,
    output logic                    o_w_ready,
    input  logic                    i_ia_valid,
    input  logic signed [15:0]      i_ia_data,
    input  logic [2:0][6:0]         i_ia_addr,
    output logic                    o_ia_ready,
    input  logic                    i_go,
    output logic                    o_start,
    output logic [2:0][6:0]         o_addr [3],
    output logic signed [15:0]      o_w [3],
    output logic signed [15:0]      o_ia [3],
    input  logic                    i_red_finish,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam int WCW = $clog2(W_DEPTH + 1);
    localparam int ICW = $clog2(IA_DEPTH + 1);
    localparam int WAW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
    localparam int IAW = (IA_DEPTH > 1) ? $clog2(IA_DEPTH) : 1;
    localparam int PW  = $clog2(W_DEPTH * IA_DEPTH + 1);

    typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                 state_reg, state_next;
    logic [WCW-1:0]         n_w_reg;
    logic [ICW-1:0]         n_ia_reg;
    logic [WCW-1:0]         it_w_reg;
    logic [ICW-1:0]         it_ia_reg;
    logic [PW-1:0]          left_reg;

    logic signed [15:0]     w_data_mem  [W_DEPTH];
    logic [2:0][6:0]        w_addr_mem  [W_DEPTH];
    logic signed [15:0]     ia_data_mem [IA_DEPTH];
    logic [2:0][6:0]        ia_addr_mem [IA_DEPTH];

    logic                   w_fire, ia_fire;
    logic [WCW-1:0]         n_w_eff;
    logic [ICW-1:0]         n_ia_eff;
    logic [PW-1:0]          p_eff;
    logic [PW-1:0]          gen_left;
    logic                   load_group;

    logic [WCW-1:0]         pos_w  [4];
    logic [ICW-1:0]         pos_ia [4];
    logic [2:0]             ent_valid;
    logic signed [15:0]     rd_w      [3];
    logic signed [15:0]     rd_ia     [3];
    logic [2:0][6:0]        rd_w_addr [3];
    logic [2:0][6:0]        rd_ia_addr[3];
    logic [2:0][6:0]        grp_addr  [3];
    logic signed [15:0]     grp_w     [3];
    logic signed [15:0]     grp_ia    [3];

    // Per-coordinate 7-bit add; no carry crosses between coordinates.
    function automatic logic [2:0][6:0] addr_sum(input logic [2:0][6:0] a,
                                                 input logic [2:0][6:0] b);
        logic [2:0][6:0] s;
        for (int k = 0; k < 3; k++) begin
            s[k] = a[k] + b[k];
        end
        return s;
    endfunction

    assign o_w_ready  = (state_reg == S_LOAD) && (n_w_reg  < WCW'(W_DEPTH));
    assign o_ia_ready = (state_reg == S_LOAD) && (n_ia_reg < ICW'(IA_DEPTH));
    assign w_fire     = i_w_valid  & o_w_ready;
    assign ia_fire    = i_ia_valid & o_ia_ready;

    // An entry accepted in the same cycle as go belongs to the tile.
    assign n_w_eff  = n_w_reg  + WCW'(w_fire);
    assign n_ia_eff = n_ia_reg + ICW'(ia_fire);
    assign p_eff    = PW'(n_w_eff) * PW'(n_ia_eff);

    assign o_start = (state_reg == S_ISSUE);
    assign o_done  = (state_reg == S_DONE);
    assign o_busy  = (state_reg != S_LOAD);

    assign pos_w[0]  = (state_reg == S_LOAD) ? '0 : it_w_reg;
    assign pos_ia[0] = (state_reg == S_LOAD) ? '0 : it_ia_reg;
    assign gen_left  = (state_reg == S_LOAD) ? p_eff : left_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_entry
            logic last_w;
            assign last_w          = ((pos_w[gi] + WCW'(1)) == n_w_eff);
            assign pos_w[gi+1]     = last_w ? '0 : pos_w[gi] + WCW'(1);
            assign pos_ia[gi+1]    = last_w ? pos_ia[gi] + ICW'(1) : pos_ia[gi];
            assign ent_valid[gi]   = (gen_left > PW'(gi));

            // Bypass the write port so the go-cycle entry is visible to group 0.
            assign rd_w[gi]        = (w_fire && pos_w[gi] == n_w_reg) ? i_w_data
                                   : w_data_mem[pos_w[gi][WAW-1:0]];
            assign rd_w_addr[gi]   = (w_fire && pos_w[gi] == n_w_reg) ? i_w_addr
                                   : w_addr_mem[pos_w[gi][WAW-1:0]];
            assign rd_ia[gi]       = (ia_fire && pos_ia[gi] == n_ia_reg) ? i_ia_data
                                   : ia_data_mem[pos_ia[gi][IAW-1:0]];
            assign rd_ia_addr[gi]  = (ia_fire && pos_ia[gi] == n_ia_reg) ? i_ia_addr
                                   : ia_addr_mem[pos_ia[gi][IAW-1:0]];

            assign grp_w[gi]       = ent_valid[gi] ? rd_w[gi]  : '0;
            assign grp_ia[gi]      = ent_valid[gi] ? rd_ia[gi] : '0;
            if (gi == 0) begin : g_first
                assign grp_addr[gi] = addr_sum(rd_ia_addr[gi], rd_w_addr[gi]);
            end else begin : g_rest
                // Padding repeats the previous address so the reducer merges it.
                assign grp_addr[gi] = ent_valid[gi] ? addr_sum(rd_ia_addr[gi], rd_w_addr[gi])
                                                    : grp_addr[gi-1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        load_group = 1'b0;
        case (state_reg)
            S_LOAD: begin
                if (i_go) begin
                    if (n_w_eff == '0 || n_ia_eff == '0) begin
                        state_next = S_DONE;
                    end else begin
                        load_group = 1'b1;
                        state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (i_red_finish) begin
                    if (left_reg != '0) begin
                        load_group = 1'b1;
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= S_LOAD;
            n_w_reg   <= '0;
            n_ia_reg  <= '0;
            it_w_reg  <= '0;
            it_ia_reg <= '0;
            left_reg  <= '0;
            for (int j = 0; j < 3; j++) begin
                o_addr[j] <= '0;
                o_w[j]    <= '0;
                o_ia[j]   <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DONE) begin
                n_w_reg  <= '0;
                n_ia_reg <= '0;
            end else begin
                if (w_fire)  n_w_reg  <= n_w_reg  + WCW'(1);
                if (ia_fire) n_ia_reg <= n_ia_reg + ICW'(1);
            end
            if (load_group) begin
                it_w_reg  <= pos_w[3];
                it_ia_reg <= pos_ia[3];
                left_reg  <= (gen_left > PW'(3)) ? gen_left - PW'(3) : '0;
                for (int j = 0; j < 3; j++) begin
                    o_addr[j] <= grp_addr[j];
                    o_w[j]    <= grp_w[j];
                    o_ia[j]   <= grp_ia[j];
                end
            end
        end
    end

    // Tile storage; contents are only meaningful below the entry counters.
    always_ff @(posedge i_clk) begin
        if (w_fire) begin
            w_data_mem[n_w_reg[WAW-1:0]] <= i_w_data;
            w_addr_mem[n_w_reg[WAW-1:0]] <= i_w_addr;
        end
        if (ia_fire) begin
            ia_data_mem[n_ia_reg[IAW-1:0]] <= i_ia_data;
            ia_addr_mem[n_ia_reg[IAW-1:0]] <= i_ia_addr;
        end
    end

endmodule
